// File: rtl/gate_truth_checker_pkg.sv
// Shared types and truth-table constants for the gate truth checker.
// Table bit i is the expected gate output when the input vector equals i.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_truth_checker_if.sv
// Stimulus/result bundle between a gate stimulus source (master) and the checker (slave).
interface gate_truth_checker_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = 8
);
    localparam int NV = 1 << N_IN;

    logic             start;
    logic             valid;
    logic [N_IN-1:0]  in_vec;
    logic             out_bit;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [NV-1:0]    coverage;
    logic [N_IN-1:0]  first_err_vec;
    logic             first_err_valid;
    logic             timeout;

    modport master (
        output start, valid, in_vec, out_bit,
        input  busy, done, pass, err_cnt, coverage, first_err_vec, first_err_valid, timeout
    );

    modport slave (
        input  start, valid, in_vec, out_bit,
        output busy, done, pass, err_cnt, coverage, first_err_vec, first_err_valid, timeout
    );

endinterface

// File: rtl/gate_truth_checker_sat_cnt.sv
// Width-parameterised up-counter that sticks at all-ones; synchronous clear wins over increment.
module gate_chk_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/gate_truth_checker.sv
// Self-checking monitor for a logic gate: compares sampled vectors against TRUTH_TABLE and tracks coverage.
// Optional idle timeout enabled by defining GATE_CHK_TIMEOUT_EN.
module gate_truth_checker
    import gate_chk_pkg::*;
#(
    parameter int                   N_IN        = 2,
    parameter logic [(1<<N_IN)-1:0] TRUTH_TABLE = TT_AND,
    parameter int                   ERR_W       = 8,
    parameter int                   TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_truth_checker_if.slave  bus
);

    localparam int NV = 1 << N_IN;

    state_e           state_q, state_d;
    logic [NV-1:0]    coverage_q, coverage_d;
    logic [N_IN-1:0]  firstErrVec_q, firstErrVec_d;
    logic             firstErrValid_q, firstErrValid_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic             runStart;
    logic             sampleEn;
    logic             mismatch;
    logic             idleExpired;
    logic [ERR_W-1:0] errCnt;

    // Start only counts outside CHECK; a coincident valid is dropped because sampleEn needs CHECK.
    assign runStart = bus.start && (state_q != CHECK);
    assign sampleEn = bus.valid && (state_q == CHECK);
    assign mismatch = sampleEn && (bus.out_bit != TRUTH_TABLE[bus.in_vec]);

    gate_chk_sat_cnt #(
        .WIDTH (ERR_W)
    ) uErrCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (runStart),
        .inc_i (mismatch),
        .cnt_o (errCnt)
    );

`ifdef GATE_CHK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idleCnt_q, idleCnt_d;

    always_comb begin
        idleCnt_d = '0;
        if ((state_q == CHECK) && !bus.valid) begin
            idleCnt_d = idleCnt_q + 1'b1;
        end
    end

    assign idleExpired = (state_q == CHECK) && !bus.valid && (idleCnt_d == IDLE_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idleCnt_q <= '0;
        end else begin
            idleCnt_q <= idleCnt_d;
        end
    end
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = (TIMEOUT_CYC > 0);
    assign idleExpired      = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        coverage_d      = coverage_q;
        firstErrVec_d   = firstErrVec_q;
        firstErrValid_d = firstErrValid_q;
        pass_d          = pass_q;
        timeout_d       = timeout_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d         = CHECK;
                    coverage_d      = '0;
                    firstErrVec_d   = '0;
                    firstErrValid_d = 1'b0;
                    pass_d          = 1'b0;
                    timeout_d       = 1'b0;
                end
            end
            CHECK: begin
                if (sampleEn) begin
                    coverage_d[bus.in_vec] = 1'b1;
                    if (mismatch && !firstErrValid_q) begin
                        firstErrVec_d   = bus.in_vec;
                        firstErrValid_d = 1'b1;
                    end
                end
                // errCnt still holds the pre-edge count, so this edge's mismatch is folded in here.
                if (&coverage_d) begin
                    state_d = DONE;
                    pass_d  = (errCnt == '0) && !mismatch;
                end else if (idleExpired) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            coverage_q      <= '0;
            firstErrVec_q   <= '0;
            firstErrValid_q <= 1'b0;
            pass_q          <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            coverage_q      <= coverage_d;
            firstErrVec_q   <= firstErrVec_d;
            firstErrValid_q <= firstErrValid_d;
            pass_q          <= pass_d;
            timeout_q       <= timeout_d;
        end
    end

    assign bus.busy            = (state_q == CHECK);
    assign bus.done            = (state_q == DONE);
    assign bus.pass            = pass_q && (state_q == DONE);
    assign bus.err_cnt         = errCnt;
    assign bus.coverage        = coverage_q;
    assign bus.first_err_vec   = firstErrVec_q;
    assign bus.first_err_valid = firstErrValid_q;
    assign bus.timeout         = timeout_q;

endmodule
